// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the sequential RV32I/M ALU.
// Opcodes 10..17 are only executed when ALU_MULDIV_EN is defined.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // First opcode of the M-extension group and first undefined opcode.
  localparam logic [4:0] OP_MULDIV_MIN  = 5'd10;
  localparam logic [4:0] OP_ILLEGAL_MIN = 5'd18;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative M-extension engine: one shift-add / restoring-subtract step per cycle.
// Only built when ALU_MULDIV_EN is defined; without it the module does not exist.
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  logic              r_busy;
  logic              r_is_div;
  logic              r_hi_sel;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [SHW-1:0]    r_cnt;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;

  logic              w_sa;
  logic              w_sb;
  logic              w_neg_a;
  logic              w_neg_b;
  logic              w_is_div;
  logic              w_hi_sel;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic [XLEN+1:0]   w_diff;
  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic              w_unused;

  always_comb begin
    w_sa     = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
    w_sb     = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
    w_is_div = is_div_op(i_op);
    w_hi_sel = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_MULHU) ||
               (i_op == OP_REM)  || (i_op == OP_REMU);
    w_neg_a  = w_sa & i_a[XLEN-1];
    w_neg_b  = w_sb & i_b[XLEN-1];
    w_mag_a  = w_neg_a ? -i_a : i_a;
    w_mag_b  = w_neg_b ? -i_b : i_b;
  end

  // r_hi is the running product high half or partial remainder; r_lo the multiplier or quotient.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = {1'b0, w_shift} - {2'b00, r_opnd};
    if (r_is_div) begin
      if (!w_diff[XLEN+1]) begin
        w_hi_nxt = w_diff[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_sum[XLEN:1];
      w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Sign fix-up is applied to the final step's output so the result lands on the last step edge.
  always_comb begin
    w_prod = r_neg_q ? -{w_hi_nxt, w_lo_nxt} : {w_hi_nxt, w_lo_nxt};
    w_quot = r_neg_q ? -w_lo_nxt : w_lo_nxt;
    w_rem  = r_neg_r ? -w_hi_nxt : w_hi_nxt;
    if (r_is_div) begin
      o_result = r_hi_sel ? w_rem : w_quot;
    end else begin
      o_result = r_hi_sel ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
    end
  end

  assign o_done   = r_busy && (r_cnt == CNT_LAST);
  assign w_unused = w_diff[XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_hi_sel <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
      r_lo     <= w_is_div ? w_mag_a : w_mag_b;
      r_is_div <= w_is_div;
      r_hi_sel <= w_hi_sel;
      r_neg_q  <= w_neg_a ^ w_neg_b;
      r_neg_r  <= w_neg_a;
    end else if (r_busy) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
      if (r_cnt == CNT_LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// Sequential RV32I/M execute unit: valid/ready handshake FSM plus single-cycle base ops.
// Define ALU_MULDIV_EN to build the iterative multiply/divide engine (else ops 10..17 are illegal).
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal
);

  alu_state_e      r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_illegal;
  logic [XLEN-1:0] r_result;

  alu_op_e         w_op;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_base_result;
  logic [XLEN-1:0] w_quick_result;
  logic            w_illegal_op;
  logic            w_go_calc;
  logic            w_md_done;
  logic [XLEN-1:0] w_md_result;

  assign w_op    = alu_op_e'(i_op);
  assign w_shamt = i_b[SHW-1:0];

  always_comb begin
    w_base_result = '0;
    case (w_op)
      OP_ADD:  w_base_result = i_a + i_b;
      OP_SUB:  w_base_result = i_a - i_b;
      OP_SLL:  w_base_result = i_a << w_shamt;
      OP_SLT:  w_base_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: w_base_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      OP_XOR:  w_base_result = i_a ^ i_b;
      OP_SRL:  w_base_result = i_a >> w_shamt;
      OP_SRA:  w_base_result = $unsigned($signed(i_a) >>> w_shamt);
      OP_OR:   w_base_result = i_a | i_b;
      OP_AND:  w_base_result = i_a & i_b;
      default: w_base_result = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  // Divide-by-zero and signed overflow resolve in one cycle and never start the engine.
  always_comb begin
    w_illegal_op   = 1'b0;
    w_go_calc      = 1'b0;
    w_quick_result = w_base_result;
    if (i_op >= OP_ILLEGAL_MIN) begin
      w_illegal_op   = 1'b1;
      w_quick_result = '0;
    end else if (i_op >= OP_MULDIV_MIN) begin
      w_quick_result = '0;
      if (is_div_op(i_op) && (i_b == '0)) begin
        w_quick_result = ((i_op == OP_REM) || (i_op == OP_REMU)) ? i_a : '1;
      end else if (((i_op == OP_DIV) || (i_op == OP_REM)) && (i_a == SMIN) && (i_b == '1)) begin
        w_quick_result = (i_op == OP_DIV) ? i_a : '0;
      end else begin
        w_go_calc = 1'b1;
      end
    end
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  ((r_state == ST_IDLE) && i_in_valid && w_go_calc),
    .i_flush  (i_flush && (r_state != ST_IDLE)),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );
`else
  always_comb begin
    w_illegal_op   = 1'b0;
    w_go_calc      = 1'b0;
    w_quick_result = w_base_result;
    if (i_op >= OP_MULDIV_MIN) begin
      w_illegal_op   = 1'b1;
      w_quick_result = '0;
    end
  end

  assign w_md_done   = 1'b0;
  assign w_md_result = '0;
`endif

  // Flush is ignored in IDLE and takes priority over out_ready in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_in_ready <= 1'b0;
            if (w_go_calc) begin
              r_state <= ST_CALC;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_quick_result;
              r_illegal   <= w_illegal_op;
            end
          end
        end
        ST_CALC: begin
          if (i_flush) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
          end else if (w_md_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_md_result;
            r_illegal   <= 1'b0;
          end
        end
        ST_DONE: begin
          if (i_flush || i_out_ready) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_illegal   = r_illegal;

endmodule
